conways_axil_regbank: RTL and testbench

- Parametrised AXI4-Lite slave register bank; successor to the fixed 4-register Conway write block.
- N_RW read/write control registers (board seed rows, run/step control) drive the game fabric; N_RO read-only status registers (generation count, live-cell count) are sampled from the fabric.
- Each RW register has a one-cycle update pulse so the fabric can react to a PS write without polling.
- Sits between the Zynq GP AXI port and the Conway engine.

---
 rtl/conways_regbank_pkg.sv | 23 ++
 rtl/conways_regbank_strb_merge.sv | 17 +
 rtl/conways_axil_regbank.sv | 249 ++++++++++++++++++++++++
 tb/tb_conways_axil_regbank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conways_regbank_pkg.sv
// Shared types, response codes and address decode for the Conway AXI4-Lite register bank.
package conways_regbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_COMMIT = 2'd1,
      WR_RESP   = 2'd2
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_t;

   // Register index of a byte address; the low addr_lsb bits select a byte lane and are dropped.
   function automatic int unsigned idx_of(input logic [63:0] addr, input int unsigned addr_lsb);
      return 32'(addr >> addr_lsb);
   endfunction

endpackage

// File: rtl/conways_regbank_strb_merge.sv
// Byte-strobe merge: each lane takes WDATA where its strobe is set, otherwise keeps the old value.
module conways_regbank_strb_merge #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_val,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   merged_c
);

   localparam int unsigned STRB_W = DATA_W / 8;

   for (genvar b = 0; b < STRB_W; b++) begin : g_byte
      assign merged_c[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old_val[b*8 +: 8];
   end

endmodule

// File: rtl/conways_axil_regbank.sv
// AXI4-Lite slave register bank for the Conway engine: N_RW control registers with per-register
// update pulses, N_RO status registers sampled from the fabric at read time.
// Build option: define CONWAYS_REGBANK_SLVERR_EN to answer out-of-range accesses and writes to
// read-only registers with SLVERR instead of OKAY (data side effects are identical either way).
module conways_axil_regbank
   import conways_regbank_pkg::*;
#(
   parameter int unsigned        DATA_W    = 32,
   parameter int unsigned        ADDR_W    = 6,
   parameter int unsigned        N_RW      = 4,
   parameter int unsigned        N_RO      = 2,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
   input  logic                     S_AXI_ACLK,
   input  logic                     S_AXI_ARESETN,
   input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
   input  logic [2:0]               S_AXI_AWPROT,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [DATA_W-1:0]        S_AXI_WDATA,
   input  logic [DATA_W/8-1:0]      S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
   input  logic [2:0]               S_AXI_ARPROT,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [DATA_W-1:0]        S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   output logic [N_RW*DATA_W-1:0]   reg_q,
   output logic [N_RW-1:0]          reg_upd,
   input  logic [N_RO*DATA_W-1:0]   status_i
);

   localparam int unsigned STRB_W   = DATA_W / 8;
   localparam int unsigned ADDR_LSB = $clog2(STRB_W);
   localparam int unsigned N_TOT    = N_RW + N_RO;
   localparam int unsigned REG_W    = N_RW * DATA_W;
   localparam int unsigned TOT_W    = N_TOT * DATA_W;
   localparam logic [DATA_W-1:0] DATA_MASK = '1;

`ifdef CONWAYS_REGBANK_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif
   localparam logic [1:0] BAD_RESP = SLVERR_EN ? RESP_SLVERR : RESP_OKAY;

   // Protection bits carry no meaning for this bank.
   logic unused_prot;
   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // ---------------------------------------------------------------- write channel
   wr_state_t           wr_state, wr_state_nxt;
   logic                aw_held, aw_held_nxt;
   logic                w_held, w_held_nxt;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_nxt;
   logic [DATA_W-1:0]   wdata_q, wdata_nxt;
   logic [STRB_W-1:0]   wstrb_q, wstrb_nxt;
   logic                awready_nxt, wready_nxt, bvalid_nxt;
   logic [1:0]          bresp_nxt;
   logic [REG_W-1:0]    reg_q_nxt;
   logic [N_RW-1:0]     reg_upd_nxt;
   int unsigned         wr_idx;
   logic [DATA_W-1:0]   wr_old;
   logic [DATA_W-1:0]   wr_merged;

   assign wr_idx = idx_of(64'(awaddr_q), ADDR_LSB);
   assign wr_old = DATA_W'(reg_q >> (wr_idx * DATA_W));

   conways_regbank_strb_merge #(
      .DATA_W (DATA_W)
   ) u_strb_merge (
      .old_val  (wr_old),
      .wdata    (wdata_q),
      .wstrb    (wstrb_q),
      .merged_c (wr_merged)
   );

   // Write FSM state and registered write-side outputs.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wr_state      <= WR_IDLE;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
         reg_q         <= {N_RW{RESET_VAL}};
         reg_upd       <= '0;
      end else begin
         wr_state      <= wr_state_nxt;
         aw_held       <= aw_held_nxt;
         w_held        <= w_held_nxt;
         awaddr_q      <= awaddr_nxt;
         wdata_q       <= wdata_nxt;
         wstrb_q       <= wstrb_nxt;
         S_AXI_AWREADY <= awready_nxt;
         S_AXI_WREADY  <= wready_nxt;
         S_AXI_BVALID  <= bvalid_nxt;
         S_AXI_BRESP   <= bresp_nxt;
         reg_q         <= reg_q_nxt;
         reg_upd       <= reg_upd_nxt;
      end
   end

   // Write FSM next state: collect AW and W in any order, commit one cycle, then hold B.
   always_comb begin : p_wr_next
      int unsigned new_idx;
      new_idx      = 0;
      wr_state_nxt = wr_state;
      aw_held_nxt  = aw_held;
      w_held_nxt   = w_held;
      awaddr_nxt   = awaddr_q;
      wdata_nxt    = wdata_q;
      wstrb_nxt    = wstrb_q;
      awready_nxt  = S_AXI_AWREADY;
      wready_nxt   = S_AXI_WREADY;
      bvalid_nxt   = S_AXI_BVALID;
      bresp_nxt    = S_AXI_BRESP;
      reg_q_nxt    = reg_q;
      reg_upd_nxt  = '0;
      case (wr_state)
         WR_IDLE: begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
               aw_held_nxt = 1'b1;
               awaddr_nxt  = S_AXI_AWADDR;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
               w_held_nxt = 1'b1;
               wdata_nxt  = S_AXI_WDATA;
               wstrb_nxt  = S_AXI_WSTRB;
            end
            if (aw_held_nxt && w_held_nxt) begin
               wr_state_nxt = WR_COMMIT;
               awready_nxt  = 1'b0;
               wready_nxt   = 1'b0;
               // The pulse marks the commit cycle; reg_q shows the new value from the next cycle.
               new_idx = idx_of(64'(awaddr_nxt), ADDR_LSB);
               if (new_idx < N_RW) begin
                  reg_upd_nxt = N_RW'(1) << new_idx;
               end
            end else begin
               awready_nxt = !aw_held_nxt;
               wready_nxt  = !w_held_nxt;
            end
         end
         WR_COMMIT: begin
            if (wr_idx < N_RW) begin
               reg_q_nxt = (reg_q & ~(REG_W'(DATA_MASK) << (wr_idx * DATA_W)))
                         | (REG_W'(wr_merged) << (wr_idx * DATA_W));
               bresp_nxt = RESP_OKAY;
            end else begin
               bresp_nxt = BAD_RESP;
            end
            bvalid_nxt   = 1'b1;
            wr_state_nxt = WR_RESP;
         end
         WR_RESP: begin
            if (S_AXI_BREADY) begin
               bvalid_nxt   = 1'b0;
               bresp_nxt    = RESP_OKAY;
               aw_held_nxt  = 1'b0;
               w_held_nxt   = 1'b0;
               awready_nxt  = 1'b1;
               wready_nxt   = 1'b1;
               wr_state_nxt = WR_IDLE;
            end
         end
         default: begin
            wr_state_nxt = WR_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- read channel
   rd_state_t           rd_state, rd_state_nxt;
   logic                arready_nxt, rvalid_nxt;
   logic [DATA_W-1:0]   rdata_nxt;
   logic [1:0]          rresp_nxt;
   int unsigned         rd_idx;
   logic [TOT_W-1:0]    rd_space;

   assign rd_idx   = idx_of(64'(S_AXI_ARADDR), ADDR_LSB);
   assign rd_space = {status_i, reg_q};

   // Read FSM state and registered read-side outputs.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rd_state      <= RD_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= RESP_OKAY;
      end else begin
         rd_state      <= rd_state_nxt;
         S_AXI_ARREADY <= arready_nxt;
         S_AXI_RVALID  <= rvalid_nxt;
         S_AXI_RDATA   <= rdata_nxt;
         S_AXI_RRESP   <= rresp_nxt;
      end
   end

   // Read FSM next state: capture register contents at AR handshake, hold R until accepted.
   always_comb begin
      rd_state_nxt = rd_state;
      arready_nxt  = S_AXI_ARREADY;
      rvalid_nxt   = S_AXI_RVALID;
      rdata_nxt    = S_AXI_RDATA;
      rresp_nxt    = S_AXI_RRESP;
      case (rd_state)
         RD_IDLE: begin
            arready_nxt = 1'b1;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
               arready_nxt  = 1'b0;
               rvalid_nxt   = 1'b1;
               rd_state_nxt = RD_DATA;
               if (rd_idx < N_TOT) begin
                  rdata_nxt = DATA_W'(rd_space >> (rd_idx * DATA_W));
                  rresp_nxt = RESP_OKAY;
               end else begin
                  rdata_nxt = '0;
                  rresp_nxt = BAD_RESP;
               end
            end
         end
         RD_DATA: begin
            if (S_AXI_RREADY) begin
               rvalid_nxt   = 1'b0;
               arready_nxt  = 1'b1;
               rd_state_nxt = RD_IDLE;
            end
         end
         default: begin
            rd_state_nxt = RD_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conways_axil_regbank.sv
// Scoreboard bench for conways_axil_regbank: tasks push expected B/R responses, a monitor pops
// and compares them on each handshake; side-band register and latency checks are inline.
`timescale 1ns/1ps
module tb_conways_axil_regbank;

`ifdef CONWAYS_REGBANK_SLVERR_EN
   localparam logic [1:0] ERR_RESP = 2'b10;
`else
   localparam logic [1:0] ERR_RESP = 2'b00;
`endif

   logic          tb_ACLK = 1'b0;
   logic          aresetn;
   logic [5:0]    awaddr;
   logic [2:0]    awprot;
   logic          awvalid;
   logic          awready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [5:0]    araddr;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;
   logic [127:0]  reg_q;
   logic [3:0]    reg_upd;
   logic [63:0]   status_i;

   logic [1:0]    b_exp_q[$];
   logic [33:0]   r_exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;

   always #5 tb_ACLK = ~tb_ACLK;

   conways_axil_regbank dut (
      .S_AXI_ACLK    (tb_ACLK),
      .S_AXI_ARESETN (aresetn),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_q         (reg_q),
      .reg_upd       (reg_upd),
      .status_i      (status_i)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Response monitor: compare every B and R handshake against the queued expectation.
   always @(negedge tb_ACLK) begin
      if (aresetn) begin
         if (bvalid && bready) begin
            check("b_pending", 128'(b_exp_q.size() != 0), 128'(1));
            if (b_exp_q.size() != 0) check("bresp", 128'(bresp), 128'(b_exp_q.pop_front()));
         end
         if (rvalid && rready) begin
            check("r_pending", 128'(r_exp_q.size() != 0), 128'(1));
            if (r_exp_q.size() != 0) check("rdata_rresp", 128'({rresp, rdata}), 128'(r_exp_q.pop_front()));
         end
      end
   end

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_delay, input logic [1:0] exp_resp, input logic [3:0] exp_upd);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      bit aw_hs, w_hs;
      int cyc = 0;
      b_exp_q.push_back(exp_resp);
      awaddr  = addr;
      awvalid = 1'b1;
      wdata   = data;
      wstrb   = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         if (!w_done && cyc >= w_delay) wvalid = 1'b1;
         @(negedge tb_ACLK);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge tb_ACLK); #1;
         if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
         cyc++;
      end
      check("wr_handshake", 128'(aw_done && w_done), 128'(1));
      @(negedge tb_ACLK);
      check("upd_commit", 128'(reg_upd), 128'(exp_upd));
      check("bvalid_lat1", 128'(bvalid), 128'(0));
      @(negedge tb_ACLK);
      check("bvalid_lat2", 128'(bvalid), 128'(1));
      check("upd_clear", 128'(reg_upd), 128'(0));
   endtask

   task automatic axi_read(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
      bit done = 1'b0;
      bit hs;
      int cyc = 0;
      r_exp_q.push_back({exp_resp, exp_data});
      araddr  = addr;
      arvalid = 1'b1;
      while (!done && cyc < 40) begin
         @(negedge tb_ACLK);
         hs = arvalid && arready;
         @(posedge tb_ACLK); #1;
         if (hs) begin done = 1'b1; arvalid = 1'b0; end
         cyc++;
      end
      check("rd_handshake", 128'(done), 128'(1));
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && cyc < 50) begin
         @(posedge tb_ACLK); #1;
         cyc++;
      end
      check("drain", 128'(b_exp_q.size() + r_exp_q.size()), 128'(0));
      @(posedge tb_ACLK); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
      wvalid = 1'b0; bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
      status_i = {32'h0000_1234, 32'h0000_002A};

      // reset state
      repeat (3) @(posedge tb_ACLK);
      @(negedge tb_ACLK);
      check("rst_readies", 128'({awready, wready, arready}), 128'(0));
      check("rst_valids", 128'({bvalid, rvalid}), 128'(0));
      check("rst_resps", 128'({bresp, rresp}), 128'(0));
      check("rst_rdata", 128'(rdata), 128'(0));
      check("rst_reg_q", reg_q, 128'(0));
      check("rst_reg_upd", 128'(reg_upd), 128'(0));
      @(posedge tb_ACLK); #1;
      aresetn = 1'b1;

      // RW registers read zero, RO registers follow status_i
      axi_read(6'h00, 32'h0000_0000, 2'b00);
      axi_read(6'h04, 32'h0000_0000, 2'b00);
      axi_read(6'h08, 32'h0000_0000, 2'b00);
      axi_read(6'h0C, 32'h0000_0000, 2'b00);
      axi_read(6'h10, 32'h0000_002A, 2'b00);
      axi_read(6'h14, 32'h0000_1234, 2'b00);
      wait_idle();

      // AW one cycle ahead of W
      axi_write(6'h00, 32'h0101_FFFF, 4'hF, 1, 2'b00, 4'b0001);
      wait_idle();
      axi_read(6'h00, 32'h0101_FFFF, 2'b00);
      wait_idle();
      check("reg0", 128'(reg_q[31:0]), 128'(32'h0101_FFFF));

      // partial strobe over a full word; byte-lane address bits ignored on read
      axi_write(6'h04, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, 4'b0010);
      wait_idle();
      axi_write(6'h04, 32'hABCD_0001, 4'b0011, 0, 2'b00, 4'b0010);
      wait_idle();
      check("reg1_strb", 128'(reg_q[63:32]), 128'(32'hDEAD_0001));
      axi_read(6'h05, 32'hDEAD_0001, 2'b00);
      wait_idle();

      // zero strobe still pulses; unaligned address selects index 3
      axi_write(6'h08, 32'hFFFF_FFFF, 4'h0, 0, 2'b00, 4'b0100);
      wait_idle();
      check("reg2_nostrb", 128'(reg_q[95:64]), 128'(0));
      axi_write(6'h0D, 32'h1234_5678, 4'hF, 0, 2'b00, 4'b1000);
      wait_idle();
      check("reg3", 128'(reg_q[127:96]), 128'(32'h1234_5678));

      // B back-pressure: response stable, next AW held off until after B handshake
      bready = 1'b0;
      axi_write(6'h0C, 32'h0000_0005, 4'hF, 0, 2'b00, 4'b1000);
      @(posedge tb_ACLK); #1;
      awaddr = 6'h08; awvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge tb_ACLK);
         check("b_hold", 128'({bvalid, bresp, awready, wready}), 128'(5'b1_00_00));
         @(posedge tb_ACLK); #1;
      end
      bready = 1'b1;
      axi_write(6'h08, 32'h0000_0077, 4'hF, 0, 2'b00, 4'b0100);
      wait_idle();
      check("regs_after_hold", reg_q, {32'h0000_0005, 32'h0000_0077, 32'hDEAD_0001, 32'h0101_FFFF});

      // read-only and out-of-range accesses
      axi_write(6'h10, 32'hFFFF_FFFF, 4'hF, 0, ERR_RESP, 4'b0000);
      wait_idle();
      axi_write(6'h38, 32'hFFFF_FFFF, 4'hF, 0, ERR_RESP, 4'b0000);
      wait_idle();
      check("regs_after_bad_wr", reg_q, {32'h0000_0005, 32'h0000_0077, 32'hDEAD_0001, 32'h0101_FFFF});
      axi_read(6'h3C, 32'h0000_0000, ERR_RESP);
      axi_read(6'h10, 32'h0000_002A, 2'b00);
      wait_idle();

      // concurrent read and write of the same register: read sees the pre-write value
      fork
         axi_write(6'h00, 32'hCAFE_0000, 4'b1100, 0, 2'b00, 4'b0001);
         axi_read(6'h00, 32'h0101_FFFF, 2'b00);
      join
      wait_idle();
      axi_read(6'h00, 32'hCAFE_FFFF, 2'b00);
      wait_idle();

      // reset while the write response is pending
      bready = 1'b0;
      axi_write(6'h00, 32'hBEEF_0011, 4'hF, 0, 2'b00, 4'b0001);
      check("regs_before_rst", reg_q, {32'h0000_0005, 32'h0000_0077, 32'hDEAD_0001, 32'hBEEF_0011});
      void'(b_exp_q.pop_back());
      #2 aresetn = 1'b0;
      #1;
      check("rst_bvalid_drop", 128'(bvalid), 128'(0));
      check("rst_reg_q_back", reg_q, 128'(0));
      check("rst_awready", 128'(awready), 128'(0));
      @(posedge tb_ACLK); #1;
      aresetn = 1'b1;
      bready  = 1'b1;
      axi_read(6'h00, 32'h0000_0000, 2'b00);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
